// File: rtl/basic_gates.sv
// Registered bitwise gate unit: one static two-input gate (GATE_SEL) applied per bit to a/b.
// Optional BASICGATES_PIPE2_EN adds a second register stage (latency 2 instead of 1).
module basic_gates #(
    parameter int WIDTH    = 2,
    parameter int GATE_SEL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y1
);

    logic [WIDTH-1:0] gate_y;

    // Unlisted selector values fall through to zeros so y1 never goes X.
    always_comb begin
        gate_y = '0;
        case (GATE_SEL)
            0:       gate_y = a & b;
            1:       gate_y = a | b;
            2:       gate_y = a ^ b;
            3:       gate_y = ~(a & b);
            4:       gate_y = ~(a | b);
            5:       gate_y = ~(a ^ b);
            6:       gate_y = ~a;
            7:       gate_y = a;
            default: gate_y = '0;
        endcase
    end

`ifdef BASICGATES_PIPE2_EN
    logic [WIDTH-1:0] stage1;

    always_ff @(posedge clk) begin
        if (rst) begin
            stage1 <= '0;
            y1     <= '0;
        end else begin
            stage1 <= gate_y;
            y1     <= stage1;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            y1 <= '0;
        end else begin
            y1 <= gate_y;
        end
    end
`endif

endmodule

// File: tb/tb_basic_gates.sv
// Directed bench for basic_gates: AND datapath, reset behaviour, gate sweep and an 8-bit XOR case.
module tb_basic_gates;

`ifdef BASICGATES_PIPE2_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] a, b;
    logic [1:0] y1;
    logic [1:0] sa, sb;
    logic [1:0] sy [9];
    logic [7:0] a8, b8, y8;

    int checks   = 0;
    int failures = 0;

    logic [1:0] sweep_a   [3];
    logic [1:0] sweep_b   [3];
    logic [1:0] sweep_exp [3][9];

    always #5 clk = ~clk;

    basic_gates #(.WIDTH(2), .GATE_SEL(0)) dut (
        .clk(clk), .rst(rst), .a(a), .b(b), .y1(y1)
    );

    for (genvar g = 0; g < 9; g++) begin : g_sweep
        basic_gates #(.WIDTH(2), .GATE_SEL((g == 8) ? 9 : g)) u_gate (
            .clk(clk), .rst(rst), .a(sa), .b(sb), .y1(sy[g])
        );
    end

    basic_gates #(.WIDTH(8), .GATE_SEL(2)) dut8 (
        .clk(clk), .rst(rst), .a(a8), .b(b8), .y1(y8)
    );

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input logic [1:0] va, input logic [1:0] vb, input logic [1:0] exp, input string tag);
        a = va;
        b = vb;
        repeat (LAT) tick();
        check_eq(tag, {6'b0, y1}, {6'b0, exp});
    endtask

    initial begin
        // order: AND OR XOR NAND NOR XNOR NOT BUF invalid(9)
        sweep_a[0] = 2'b01; sweep_b[0] = 2'b11;
        sweep_exp[0] = '{2'b01, 2'b11, 2'b10, 2'b10, 2'b00, 2'b01, 2'b10, 2'b01, 2'b00};
        sweep_a[1] = 2'b10; sweep_b[1] = 2'b10;
        sweep_exp[1] = '{2'b10, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11, 2'b01, 2'b10, 2'b00};
        sweep_a[2] = 2'b10; sweep_b[2] = 2'b01;
        sweep_exp[2] = '{2'b00, 2'b11, 2'b11, 2'b11, 2'b00, 2'b00, 2'b01, 2'b10, 2'b00};

        rst = 1'b1;
        a = 2'b00; b = 2'b00;
        sa = 2'b11; sb = 2'b11;
        a8 = 8'hFF; b8 = 8'h00;
        tick();
        check_eq("reset y1", {6'b0, y1}, 8'h00);
        check_eq("reset y8", y8, 8'h00);
        check_eq("reset nand", {6'b0, sy[3]}, 8'h00);

        a = 2'b11; b = 2'b11;
        tick();
        check_eq("reset hold y1", {6'b0, y1}, 8'h00);
        check_eq("reset hold nor", {6'b0, sy[4]}, 8'h00);

        rst = 1'b0;
        apply(2'b00, 2'b11, 2'b00, "and 00/11");
        apply(2'b00, 2'b01, 2'b00, "and 00/01");
        apply(2'b01, 2'b10, 2'b00, "and 01/10");
        apply(2'b10, 2'b11, 2'b10, "and 10/11");
        apply(2'b11, 2'b11, 2'b11, "and 11/11");

        a = 2'b00;
        #3;
        check_eq("between edges", {6'b0, y1}, 8'h03);
        a = 2'b11;

        rst = 1'b1;
        tick();
        check_eq("mid reset", {6'b0, y1}, 8'h00);
        rst = 1'b0;
`ifdef BASICGATES_PIPE2_EN
        tick();
        check_eq("pipe fill zero", {6'b0, y1}, 8'h00);
        tick();
        check_eq("pipe first result", {6'b0, y1}, 8'h03);
`else
        tick();
        check_eq("after reset", {6'b0, y1}, 8'h03);
`endif

        a8 = 8'hA5; b8 = 8'h0F;
        for (int v = 0; v < 3; v++) begin
            sa = sweep_a[v];
            sb = sweep_b[v];
            repeat (LAT) tick();
            for (int g = 0; g < 9; g++) begin
                check_eq($sformatf("sweep v%0d g%0d", v, g), {6'b0, sy[g]}, {6'b0, sweep_exp[v][g]});
            end
        end
        check_eq("xor8 a5^0f", y8, 8'hAA);

        a8 = 8'h3C; b8 = 8'hFF;
        repeat (LAT) tick();
        check_eq("xor8 3c^ff", y8, 8'hC3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
